// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bus: the recovered byte and its two completion strobes.
// uart_rx drives it through the master modport. Downstream logic listens
// through the slave modport.
interface uart_rx_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;

    modport master (
        output o_data,
        output o_rx_done,
        output o_frame_err
    );

    modport slave (
        input o_data,
        input o_rx_done,
        input o_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, LSB first.
// The line is resynchronised to the clock. The 16x baud tick then times the
// centre of the start bit, the centre of every data bit and the end of the
// stop period. A completed frame ends in exactly one one-cycle strobe:
// o_rx_done when the stop bit is good (o_data is updated in the same cycle),
// or o_frame_err when the stop bit is bad (o_data keeps its old value).
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int N_SYNC  = 2
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_rx,
    input  logic      i_tick,
    uart_rx_if.master rx_bus
);

    localparam int S_W = $clog2(SB_TICK);
    localparam int N_W = $clog2(NB_DATA) + 1;

    // Tick counts: half a bit (start-bit centre), a full bit, and the stop period
    localparam logic [S_W-1:0] S_MID      = S_W'(7);
    localparam logic [S_W-1:0] S_BIT_END  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST     = N_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [N_SYNC-1:0]  sync_reg;
    logic               rx_s;

    state_t             state_reg,  state_next;
    logic [S_W-1:0]     s_reg,      s_next;
    logic [N_W-1:0]     n_reg,      n_next;
    logic [NB_DATA-1:0] shreg_reg,  shreg_next;
    logic [NB_DATA-1:0] data_reg,   data_next;
    logic               done_reg,   done_next;
    logic               err_reg,    err_next;

    // Resynchronise the asynchronous line. The flops preset to 1 (idle) so a
    // reset cannot look like a start bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[N_SYNC-2:0], i_rx};
        end
    end

    assign rx_s = sync_reg[N_SYNC-1];

    // State, counters, shift register and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            shreg_reg <= '0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            shreg_reg <= shreg_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Frame sequencing. Counters move only on tick cycles, so a stalled tick
    // freezes the receiver in place. The strobes default low, which makes them
    // one cycle wide.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        shreg_next = shreg_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                // The falling edge is acted on at once. A tick in this same
                // cycle is not counted.
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (s_reg == S_MID) begin
                        s_next = '0;
                        if (!rx_s) begin
                            // The line is still low at the centre: a real start bit
                            state_next = DATA;
                            n_next     = '0;
                        end else begin
                            // The line went high before the centre: a glitch
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (s_reg == S_BIT_END) begin
                        // Bits arrive LSB first, so shift in from the top
                        shreg_next = {rx_s, shreg_reg[NB_DATA-1:1]};
                        s_next     = '0;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            STOP: begin
                if (i_tick) begin
                    if (s_reg == S_STOP_END) begin
                        // Return to IDLE here, so a following start bit with
                        // no idle gap is still caught.
                        state_next = IDLE;
                        s_next     = '0;
                        if (rx_s) begin
                            data_next = shreg_reg;
                            done_next = 1'b1;
                        end else begin
                            err_next  = 1'b1;
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
                s_next     = '0;
            end
        endcase
    end

    assign rx_bus.o_data      = data_reg;
    assign rx_bus.o_rx_done   = done_reg;
    assign rx_bus.o_frame_err = err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Frames are driven onto the serial line with
// cycle-accurate bit timing. A queue holds the outcome each frame must produce
// (good byte, framing error, or nothing). The compare process checks every
// strobe and the held byte against that queue on every cycle. Literal
// expectations after each scenario pin the model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int NB_DATA = 8;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset;
    logic i_rx;
    logic i_tick;

    uart_rx_if #(.NB_DATA(NB_DATA)) rx_bus ();

    uart_rx #(
        .NB_DATA (NB_DATA),
        .SB_TICK (16),
        .N_SYNC  (2)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_rx    (i_rx),
        .i_tick  (i_tick),
        .rx_bus  (rx_bus)
    );

    // 50 MHz system clock
    always #10 i_clk = ~i_clk;

    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   tick_div  = 4;
    int   tick_cnt  = 0;
    exp_t exp_q[$];
    logic [7:0] model_data = 8'h00;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    // Baud tick: a one-cycle pulse every tick_div clocks, driven just after the edge
    initial begin
        i_tick = 1'b0;
        forever begin
            @(posedge i_clk);
            #2;
            tick_cnt++;
            if (tick_cnt >= tick_div) begin
                tick_cnt = 0;
                i_tick   = 1'b1;
            end else begin
                i_tick   = 1'b0;
            end
        end
    end

    // Compare process: sample on the falling edge, away from the active edge
    always @(negedge i_clk) begin
        exp_t e;
        if (i_reset) begin
            exp_q.delete();
            model_data = 8'h00;
            checks++;
            if (rx_bus.o_data !== 8'h00 || rx_bus.o_rx_done !== 1'b0 || rx_bus.o_frame_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: data=%h done=%b err=%b required data=00 done=0 err=0",
                         rx_bus.o_data, rx_bus.o_rx_done, rx_bus.o_frame_err);
            end
        end else begin
            if (rx_bus.o_rx_done || rx_bus.o_frame_err) begin
                checks++;
                if (rx_bus.o_rx_done && rx_bus.o_frame_err) begin
                    failures++;
                    $display("FAIL both_strobes: done=1 err=1 required at most one");
                end
            end
            if (rx_bus.o_rx_done) begin
                done_cnt++;
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("FAIL done_width: done high 2 cycles, required 1");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: data=%h required no strobe", rx_bus.o_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        failures++;
                        $display("FAIL strobe_kind: got done data=%h required frame_err", rx_bus.o_data);
                    end else begin
                        model_data = e.data;
                    end
                end
            end
            if (rx_bus.o_frame_err) begin
                err_cnt++;
                checks++;
                if (prev_err) begin
                    failures++;
                    $display("FAIL err_width: frame_err high 2 cycles, required 1");
                end
                if (!rx_bus.o_rx_done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_err: frame_err with no frame pending");
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_err) begin
                            failures++;
                            $display("FAIL strobe_kind: got frame_err required done data=%h", e.data);
                        end
                    end
                end
            end
            checks++;
            if (rx_bus.o_data !== model_data) begin
                failures++;
                if (failures < 30)
                    $display("FAIL data_hold: o_data=%h required=%h", rx_bus.o_data, model_data);
            end
        end
        prev_done = rx_bus.o_rx_done;
        prev_err  = rx_bus.o_frame_err;
    end

    // Hold the line at v for the given number of clocks. Changes land 2 ns after an edge.
    task automatic hold_line(input logic v, input int cycles);
        i_rx = v;
        repeat (cycles) @(posedge i_clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_cyc,
                              input logic stop_val, input int stop_cyc);
        hold_line(1'b0, bit_cyc);
        for (int i = 0; i < 8; i++) hold_line(b[i], bit_cyc);
        hold_line(stop_val, stop_cyc);
    endtask

    task automatic expect_done(input logic [7:0] b);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = b;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    // Wait, within a bounded number of cycles, for every queued outcome to appear
    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge i_clk);
            k++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: pending=%0d required=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Watchdog: the whole run stays far below this time
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (5) @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        hold_line(1'b1, 20);
        check_lit("reset_data", int'(rx_bus.o_data), 'h00);
        check_lit("reset_done", int'(rx_bus.o_rx_done), 0);

        // 1: 0x55 with the real 9600-baud tick from 50 MHz (325 clocks/tick, 5208 clocks/bit)
        tick_div = 325;
        hold_line(1'b1, 400);
        expect_done(8'h55);
        send_frame(8'h55, 5208, 1'b1, 5208);
        drain("t1", 2000);
        check_lit("t1_data", int'(rx_bus.o_data), 'h55);
        check_lit("t1_done_cnt", done_cnt, 1);
        check_lit("t1_err_cnt", err_cnt, 0);

        // Fast tick from here on: 4 clocks/tick, 64 clocks/bit
        tick_div = 4;
        hold_line(1'b1, 40);

        // 2: three frames with no idle gap between them
        expect_done(8'h00);
        expect_done(8'hFF);
        expect_done(8'hA3);
        send_frame(8'h00, 64, 1'b1, 64);
        send_frame(8'hFF, 64, 1'b1, 64);
        send_frame(8'hA3, 64, 1'b1, 64);
        hold_line(1'b1, 128);
        drain("t2", 500);
        check_lit("t2_data", int'(rx_bus.o_data), 'hA3);
        check_lit("t2_done_cnt", done_cnt, 4);

        // 3: a low glitch of 3 ticks is rejected at the start-bit centre
        hold_line(1'b0, 12);
        hold_line(1'b1, 200);
        check_lit("t3_data", int'(rx_bus.o_data), 'hA3);
        check_lit("t3_done_cnt", done_cnt, 4);

        // 4: 0x3C with its stop bit low for 12 ticks gives a framing error
        expect_err();
        send_frame(8'h3C, 64, 1'b0, 48);
        hold_line(1'b1, 200);
        drain("t4", 500);
        check_lit("t4_err_cnt", err_cnt, 1);
        check_lit("t4_done_cnt", done_cnt, 4);
        check_lit("t4_data", int'(rx_bus.o_data), 'hA3);

        // 5: reset after the 4th data bit of 0xF0, then receive 0x81
        hold_line(1'b0, 64);                  // start bit
        for (int i = 0; i < 4; i++) hold_line(1'b0, 64);
        hold_line(1'b1, 20);                  // into data bit 4
        #3;
        i_reset = 1'b1;                       // asserted between clock edges
        hold_line(1'b1, 10);
        i_reset = 1'b0;
        check_lit("t5_reset_data", int'(rx_bus.o_data), 'h00);
        hold_line(1'b1, 400);                 // rest of the aborted frame plus idle
        check_lit("t5_done_cnt_mid", done_cnt, 4);
        expect_done(8'h81);
        send_frame(8'h81, 64, 1'b1, 64);
        hold_line(1'b1, 64);
        drain("t5", 500);
        check_lit("t5_data", int'(rx_bus.o_data), 'h81);
        check_lit("t5_done_cnt", done_cnt, 5);

        // 6: 0xC7 with bit periods 3% slow (66 clocks) and then 3% fast (62 clocks)
        expect_done(8'hC7);
        send_frame(8'hC7, 66, 1'b1, 66);
        hold_line(1'b1, 64);
        drain("t6a", 500);
        check_lit("t6a_data", int'(rx_bus.o_data), 'hC7);
        expect_done(8'hC7);
        send_frame(8'hC7, 62, 1'b1, 62);
        hold_line(1'b1, 64);
        drain("t6b", 500);
        check_lit("t6b_data", int'(rx_bus.o_data), 'hC7);
        check_lit("t6_done_cnt", done_cnt, 7);
        check_lit("t6_err_cnt", err_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
